vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Source end of the DrawX/DrawY/blank pixel interface consumed by the map and sprite drawers.
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock: pixel coordinates, a visible-area flag, and horizontal/vertical sync.
- Provides sync copies delayed to match the drawers' one-cycle registered RGB path, plus frame/line strobes for game-logic updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline stages applied to hs_d/vs_d/blank_d (0..4)
- SYNC_ACTIVE, 0, level of hs/vs while the sync pulse is active

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; all logic on posedge
- reset  in  1  asynchronous, active-high
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (DrawX<H_ACTIVE and DrawY<V_ACTIVE), aligned with DrawX/DrawY
- hs  out  1  horizontal sync, aligned with DrawX
- vs  out  1  vertical sync, aligned with DrawY
- hs_d  out  1  hs delayed SYNC_DELAY cycles, drives the connector
- vs_d  out  1  vs delayed SYNC_DELAY cycles
- blank_d  out  1  blank delayed SYNC_DELAY cycles
- line_start  out  1  1-cycle pulse when DrawX==0
- frame_start  out  1  1-cycle pulse when DrawX==0 and DrawY==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). An elaboration-time check fails if either total exceeds 1024.
- Reset asynchronously forces the following, held until reset falls:
  - DrawX = H_TOTAL-1 (799), DrawY = V_TOTAL-1 (524)
  - blank = 0, line_start = 0, frame_start = 0
  - hs = vs = ~SYNC_ACTIVE
  - all delay-stage registers: blank 0, syncs ~SYNC_ACTIVE
- Counters on each posedge:
  - If DrawX==H_TOTAL-1, DrawX wraps to 0 and DrawY advances; otherwise DrawX+1.
  - DrawY advances as DrawY+1, wrapping from V_TOTAL-1 to 0.
- The first posedge after reset release yields (0,0) with blank=1, line_start=1, frame_start=1.
- Every other output is a register computed from the next counter values, so all outputs change on the same edge as DrawX/DrawY. There is zero latency between the coordinates and blank/hs/vs/strobes.
- Sync windows:
  - hs = SYNC_ACTIVE when H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs = SYNC_ACTIVE when V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line.
- Delay line: hs_d/vs_d/blank_d equal hs/vs/blank SYNC_DELAY cycles earlier. SYNC_DELAY=0 makes them identical to the undelayed outputs. With the default of 1, hs_d/vs_d line up with the drawers' registered red/green/blue.
- Rates: line_start once per 800 cycles; frame_start once per 420000 cycles.
- Reset mid-frame: counters jump to (799,524) asynchronously; the frame restarts cleanly at (0,0) on the first edge after release. No partial sync pulse is extended.
- No other inputs. The block free-runs and cannot stall.

Decomposition:
- Package vga_pkg:
  - default timing constants (H_ACTIVE ... V_BP)
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - coord_t = logic [9:0]
- Sub-module vga_delay_line: parameterised width and depth shift register with asynchronous reset to a parameter value. Instantiated once, 3 bits wide, for {hs, vs, blank}.

Test Plan:
- Reset held 5 cycles, then released: during reset DrawX=799, DrawY=524, blank=0, hs=vs=1. First edge after release gives DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
- Run one line: blank=1 for DrawX 0..639 and 0 for 640..799. hs=0 exactly for DrawX 656..751 (96 cycles). line_start pulses only at DrawX=0.
- Run a full frame (420000 cycles): vs=0 exactly for DrawY 490..491 (1600 cycles). blank=0 for all of DrawY 480..524. Next frame_start comes exactly 420000 cycles after the previous one.
- SYNC_DELAY=1: hs_d and blank_d equal hs and blank shifted by one cycle (hs_d falls at DrawX=657). Repeat with SYNC_DELAY=0 (identical) and SYNC_DELAY=3 (hs_d falls at DrawX=659).
- Assert reset asynchronously at DrawX=300, DrawY=200, mid-clock: outputs take reset values immediately. After release the sequence restarts at (0,0) with frame_start=1.
- Wrap check: DrawX=799, DrawY=524 goes to (0,0) on the next edge. DrawX=799, DrawY=100 goes to (0,101). DrawX never exceeds 799 and DrawY never exceeds 524 across 3 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz VGA timing generator.
`timescale 1ns/1ps
package vga_pkg;

  // Default 640x480@60 Hz timing, 25 MHz pixel clock
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Derived defaults: totals and sync windows as half-open [START, END)
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // Coordinates are 10 bits wide, so neither total may exceed 1024
  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Sync/visibility bundle carried through the output delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // True when lo <= v < hi; compared as int so an end bound of 1024 still works
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a programmable value.
// DEPTH=0 degenerates to a straight wire.
`timescale 1ns/1ps
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset have no loads in the bypass case
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign data_o = data_i;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_q;
        if (gi == 0) begin : g_first
          // First stage captures the live input
          always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) stage_q <= RESET_VAL;
            else       stage_q <= data_i;
          end
        end else begin : g_next
          // Later stages shift from the previous stage
          always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) stage_q <= RESET_VAL;
            else       stage_q <= g_stage[gi-1].stage_q;
          end
        end
      end
      assign data_o = g_stage[DEPTH-1].stage_q;
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered
// visibility, sync and strobe outputs that change on the same edge as the
// coordinates, plus delayed sync copies matching the drawers' RGB register.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter int   SYNC_DELAY  = 1,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic   vga_clk,
  input  logic   reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   hs_d,
  output logic   vs_d,
  output logic   blank_d,
  output logic   line_start,
  output logic   frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // Idle level of the sync bundle: syncs inactive, not visible
  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, blank: 1'b0};

  generate
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_delay_check
      $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end
  endgenerate

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  sync_t  sync_q, sync_d;
  logic   line_q, line_d;
  logic   frame_q, frame_d;
  sync_t  sync_dly;

  // Next coordinates, and every flag derived from those next coordinates
  // so that flags and counters update together with zero skew
  always_comb begin
    x_d = x_q + coord_t'(1);
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
    end
    sync_d.blank = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    sync_d.hs    = in_window(x_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_d.vs    = in_window(y_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_d       = (x_d == '0);
    frame_d      = (x_d == '0) && (y_d == '0);
  end

  // Reset parks counters on the last pixel so the first edge lands on (0,0)
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      sync_q  <= SYNC_IDLE;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sync_q  <= sync_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .data_i (sync_q),
    .data_o (sync_dly)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = sync_q.blank;
  assign hs          = sync_q.hs;
  assign vs          = sync_q.vs;
  assign hs_d        = sync_dly.hs;
  assign vs_d        = sync_dly.vs;
  assign blank_d     = sync_dly.blank;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances share one clock/reset:
// dut0 uses full 640x480 timing (delay 1); dut1/dut2 use a short 30-line frame
// (delay 3 and 0) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic blank, hs, vs, hs_d, vs_d, blank_d, ls, fs;
  } sig_t;

  typedef struct packed {
    logic [31:0] t;
    sig_t        s;
  } exp_t;

  localparam int HT  = 800;
  localparam int HA  = 640;
  localparam int HSS = 656;
  localparam int HSE = 752;
  localparam int VSW = 2;

  int cfg_vt [3] = '{525, 30, 30};
  int cfg_va [3] = '{480, 20, 20};
  int cfg_vss[3] = '{490, 23, 23};
  int cfg_dly[3] = '{1, 3, 0};
  int exp_fall[3] = '{657, 659, 656};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] dx[3], dy[3];
  logic blk[3], hs[3], vs[3], hsd[3], vsd[3], blkd[3], ls[3], fs[3];

  vga_timing_gen #(.SYNC_DELAY(1)) dut0 (
    .vga_clk(clk), .reset(rst), .DrawX(dx[0]), .DrawY(dy[0]), .blank(blk[0]),
    .hs(hs[0]), .vs(vs[0]), .hs_d(hsd[0]), .vs_d(vsd[0]), .blank_d(blkd[0]),
    .line_start(ls[0]), .frame_start(fs[0]));

  vga_timing_gen #(.V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_DELAY(3)) dut1 (
    .vga_clk(clk), .reset(rst), .DrawX(dx[1]), .DrawY(dy[1]), .blank(blk[1]),
    .hs(hs[1]), .vs(vs[1]), .hs_d(hsd[1]), .vs_d(vsd[1]), .blank_d(blkd[1]),
    .line_start(ls[1]), .frame_start(fs[1]));

  vga_timing_gen #(.V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_DELAY(0)) dut2 (
    .vga_clk(clk), .reset(rst), .DrawX(dx[2]), .DrawY(dy[2]), .blank(blk[2]),
    .hs(hs[2]), .vs(vs[2]), .hs_d(hsd[2]), .vs_d(vsd[2]), .blank_d(blkd[2]),
    .line_start(ls[2]), .frame_start(fs[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Undelayed outputs t edges after reset release (t<=0 means in/at reset)
  function automatic sig_t ref_raw(int cfg, int t);
    sig_t r;
    int p, x, y;
    r = '0;
    if (t <= 0) begin
      r.x  = 10'(HT - 1);
      r.y  = 10'(cfg_vt[cfg] - 1);
      r.hs = 1'b1;
      r.vs = 1'b1;
    end else begin
      p = (t - 1) % (HT * cfg_vt[cfg]);
      x = p % HT;
      y = p / HT;
      r.x     = 10'(x);
      r.y     = 10'(y);
      r.blank = (x < HA) && (y < cfg_va[cfg]);
      r.hs    = !((x >= HSS) && (x < HSE));
      r.vs    = !((y >= cfg_vss[cfg]) && (y < cfg_vss[cfg] + VSW));
      r.ls    = (x == 0);
      r.fs    = (p == 0);
    end
    return r;
  endfunction

  function automatic sig_t ref_model(int cfg, int t);
    sig_t r, d;
    r = ref_raw(cfg, t);
    d = ref_raw(cfg, t - cfg_dly[cfg]);
    r.hs_d    = d.hs;
    r.vs_d    = d.vs;
    r.blank_d = d.blank;
    return r;
  endfunction

  function automatic sig_t act_of(int i);
    sig_t a;
    a.x = dx[i]; a.y = dy[i]; a.blank = blk[i]; a.hs = hs[i]; a.vs = vs[i];
    a.hs_d = hsd[i]; a.vs_d = vsd[i]; a.blank_d = blkd[i]; a.ls = ls[i]; a.fs = fs[i];
    return a;
  endfunction

  task automatic sb_cmp(input int i, input exp_t e, input sig_t a);
    n_checks++;
    if (a !== e.s)
      $display("FAIL sb_dut%0d t=%0d: got x=%0d y=%0d bl=%b hs=%b vs=%b hsd=%b vsd=%b bld=%b ls=%b fs=%b, expected x=%0d y=%0d bl=%b hs=%b vs=%b hsd=%b vsd=%b bld=%b ls=%b fs=%b",
               i, e.t, a.x, a.y, a.blank, a.hs, a.vs, a.hs_d, a.vs_d, a.blank_d, a.ls, a.fs,
               e.s.x, e.s.y, e.s.blank, e.s.hs, e.s.vs, e.s.hs_d, e.s.vs_d, e.s.blank_d, e.s.ls, e.s.fs);
    else n_pass++;
  endtask

  // Expected-response producer: every active edge is a stimulus event
  int   t_model = 0;
  exp_t q0[$], q1[$], q2[$];
  always @(posedge clk) begin
    exp_t e;
    if (rst) t_model = 0;
    else     t_model++;
    e.t = t_model; e.s = ref_model(0, t_model); q0.push_back(e);
    e.t = t_model; e.s = ref_model(1, t_model); q1.push_back(e);
    e.t = t_model; e.s = ref_model(2, t_model); q2.push_back(e);
  end

  // Monitor: compares what each DUT presents against the queued expectation
  always @(negedge clk) begin
    if (q0.size() > 0) sb_cmp(0, q0.pop_front(), act_of(0));
    if (q1.size() > 0) sb_cmp(1, q1.pop_front(), act_of(1));
    if (q2.size() > 0) sb_cmp(2, q2.pop_front(), act_of(2));
  end

  // Aggregate per-line / per-frame measurements
  int cyc1 = 0, vs_low1 = 0, blank1 = 0, frames1 = 0;
  bit have_fs1 = 0;
  int lcyc0 = 0, hs_low0 = 0, blank0 = 0, line_y0 = 0;
  bit have_ls0 = 0;
  bit hsd_prev[3] = '{1, 1, 1};
  bit fall_seen[3] = '{0, 0, 0};
  bit wrap_pend = 0;
  int max_x1 = 0, max_y1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      have_fs1  = 0;
      have_ls0  = 0;
      wrap_pend = 0;
      for (int i = 0; i < 3; i++) hsd_prev[i] = 1'b1;
    end else begin
      if (fs[1]) begin
        if (have_fs1) begin
          chk("frame_period_dut1", cyc1, 24000);
          chk("vs_low_cycles_dut1", vs_low1, 1600);
          chk("blank_cycles_frame_dut1", blank1, 12800);
        end
        frames1++;
        $display("dut1 frame %0d start at t=%0d", frames1, t_model);
        have_fs1 = 1; cyc1 = 0; vs_low1 = 0; blank1 = 0;
      end
      cyc1++;
      if (!vs[1]) vs_low1++;
      if (blk[1]) blank1++;

      if (ls[0]) begin
        if (have_ls0) begin
          chk("line_period_dut0", lcyc0, 800);
          chk("hs_low_cycles_dut0", hs_low0, 96);
          chk("blank_cycles_line_dut0", blank0, (line_y0 < 480) ? 640 : 0);
        end
        have_ls0 = 1; lcyc0 = 0; hs_low0 = 0; blank0 = 0; line_y0 = int'(dy[0]);
      end
      lcyc0++;
      if (!hs[0]) hs_low0++;
      if (blk[0]) blank0++;

      for (int i = 0; i < 3; i++) begin
        if (hsd_prev[i] && !hsd[i] && !fall_seen[i]) begin
          chk($sformatf("hs_d_fall_x_dut%0d", i), dx[i], exp_fall[i]);
          fall_seen[i] = 1;
        end
        hsd_prev[i] = hsd[i];
      end

      if (wrap_pend) begin
        chk("wrap_799_100_x_dut0", dx[0], 0);
        chk("wrap_799_100_y_dut0", dy[0], 101);
        wrap_pend = 0;
      end
      if (dx[0] == 10'd799 && dy[0] == 10'd100) wrap_pend = 1;

      if (int'(dx[1]) > max_x1) max_x1 = int'(dx[1]);
      if (int'(dy[1]) > max_y1) max_y1 = int'(dy[1]);
    end
  end

  initial begin
    bit found;
    int hold;
    int tail;
    rst = 1'b0;
    #5 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_x_dut0", dx[0], 799);
    chk("rst_y_dut0", dy[0], 524);
    chk("rst_blank_dut0", blk[0], 0);
    chk("rst_hs_dut0", hs[0], 1);
    chk("rst_vs_dut0", vs[0], 1);
    chk("rst_fs_dut0", fs[0], 0);
    chk("rst_y_dut1", dy[1], 29);
    #24 rst = 1'b0;
    $display("reset released after 5 cycles");
    @(posedge clk);
    #1;
    chk("first_x_dut0", dx[0], 0);
    chk("first_y_dut0", dy[0], 0);
    chk("first_blank_dut0", blk[0], 1);
    chk("first_ls_dut0", ls[0], 1);
    chk("first_fs_dut0", fs[0], 1);

    repeat (71999) @(posedge clk);

    found = 0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dx[1] == 10'd300 && dy[1] == 10'd12) found = 1;
    end
    chk("reach_300_12_dut1", found, 1);

    #24 rst = 1'b1;
    #1;
    $display("mid-frame reset asserted at t=%0d", t_model);
    chk("midrst_x_dut1", dx[1], 799);
    chk("midrst_y_dut1", dy[1], 29);
    chk("midrst_x_dut0", dx[0], 799);
    chk("midrst_y_dut0", dy[0], 524);
    chk("midrst_blank_dut0", blk[0], 0);
    chk("midrst_ls_dut0", ls[0], 0);
    chk("midrst_fs_dut0", fs[0], 0);
    chk("midrst_hs_dut1", hs[1], 1);
    chk("midrst_hs_d_dut0", hsd[0], 1);
    chk("midrst_blank_d_dut1", blkd[1], 0);

    hold = $urandom_range(1, 6);
    repeat (hold) @(posedge clk);
    #25 rst = 1'b0;
    $display("mid-frame reset released after %0d cycles", hold);
    @(posedge clk);
    #1;
    chk("restart_x_dut0", dx[0], 0);
    chk("restart_y_dut0", dy[0], 0);
    chk("restart_fs_dut0", fs[0], 1);
    chk("restart_fs_dut1", fs[1], 1);

    tail = 800 * $urandom_range(2, 3);
    repeat (tail) @(posedge clk);
    #1;
    chk("max_x_dut1", max_x1, 799);
    chk("max_y_dut1", max_y1, 29);
    chk("frames_seen_dut1", frames1, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
